// File: rtl/core_pkg.sv
// Shared core constants: data/register sizing, flag bit order, write modes and
// the byte-lane merge used by both the register array write and the bypass path.
package core_pkg;
  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int AW     = $clog2(NREGS);
  localparam int FLAG_W = 3;

  // Flag ordering matches the ALU FLAG output.
  localparam int FLAG_N = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;

  localparam logic [1:0] WM_FULL = 2'b00;
  localparam logic [1:0] WM_LOW  = 2'b01;
  localparam logic [1:0] WM_HIGH = 2'b10;
  localparam logic [1:0] WM_NONE = 2'b11;

  // Byte modes always source the new lane from din[7:0].
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] din,
                                                   input logic [1:0]        mode);
    logic [DATA_W-1:0] r;
    case (mode)
      WM_FULL: r = din;
      WM_LOW:  r = {old_w[DATA_W-1:DATA_W/2], din[DATA_W/2-1:0]};
      WM_HIGH: r = {din[DATA_W/2-1:0], old_w[DATA_W/2-1:0]};
      default: r = old_w;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/flag_reg.sv
// N/V/Z flag register with per-bit write enables.
// Optional same-cycle forwarding under REGFILE_BYPASS_EN.
module flag_reg
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [FLAG_W-1:0] we,
  input  logic [FLAG_W-1:0] din,
  output logic [FLAG_W-1:0] flags
);
  logic [FLAG_W-1:0] q;
  logic [FLAG_W-1:0] fwd;

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else begin
      for (int i = 0; i < FLAG_W; i++)
        if (we[i]) q[i] <= din[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd = (we & din) | (~we & q);
`else
  assign fwd = q;
`endif

  assign flags = rst ? '0 : fwd;
endmodule

// File: rtl/regfile_flags.sv
// 16x16 general register file (R0 hardwired to zero) plus N/V/Z flags feeding the ALU.
// REGFILE_BYPASS_EN enables write-to-read forwarding of registers and flags.
module regfile_flags
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     SrcReg1,
  input  logic [AW-1:0]     SrcReg2,
  input  logic [AW-1:0]     DstReg,
  input  logic              WriteReg,
  input  logic [1:0]        WriteMode,
  input  logic [DATA_W-1:0] DstData,
  input  logic [FLAG_W-1:0] FlagWE,
  input  logic [FLAG_W-1:0] FlagIn,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2,
  output logic [FLAG_W-1:0] FlagOut
);
  logic [NREGS-1:0][DATA_W-1:0] mem;
  logic                         wr_en;
  logic [DATA_W-1:0]            merged;
  logic [1:0][AW-1:0]           raddr;
  logic [1:0][DATA_W-1:0]       rdata;

  assign wr_en  = WriteReg && (DstReg != '0) && (WriteMode != WM_NONE);
  assign merged = byte_merge(mem[DstReg], DstData, WriteMode);

  // mem[0] is never written, so reset keeps it at zero permanently.
  always_ff @(posedge clk) begin
    if (rst) mem <= '0;
    else if (wr_en) mem[DstReg] <= merged;
  end

  assign raddr = {SrcReg2, SrcReg1};

  always_comb begin
    rdata = '0;
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem[raddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && raddr[p] == DstReg) rdata[p] = merged;
`endif
      if (rst || raddr[p] == '0) rdata[p] = '0;
    end
  end

  assign SrcData1 = rdata[0];
  assign SrcData2 = rdata[1];

  flag_reg u_flags (
    .clk   (clk),
    .rst   (rst),
    .we    (FlagWE),
    .din   (FlagIn),
    .flags (FlagOut)
  );
endmodule

// File: tb/tb_regfile_flags.sv
// Directed bench for regfile_flags; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_flags;
  logic        clk = 0;
  logic        rst;
  logic [3:0]  SrcReg1, SrcReg2, DstReg;
  logic        WriteReg;
  logic [1:0]  WriteMode;
  logic [15:0] DstData;
  logic [2:0]  FlagWE, FlagIn;
  logic [15:0] SrcData1, SrcData2;
  logic [2:0]  FlagOut;

  int vectors = 0;
  int errs    = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_flags dut (
    .clk(clk), .rst(rst), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .DstReg(DstReg),
    .WriteReg(WriteReg), .WriteMode(WriteMode), .DstData(DstData), .FlagWE(FlagWE),
    .FlagIn(FlagIn), .SrcData1(SrcData1), .SrcData2(SrcData2), .FlagOut(FlagOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1; SrcReg1 = 0; SrcReg2 = 0; DstReg = 0; WriteReg = 0; WriteMode = 2'b00;
    DstData = 0; FlagWE = 0; FlagIn = 0;
    tick();
    // Writes and flag loads during reset must be ignored; outputs forced to 0.
    DstReg = 4; WriteReg = 1; DstData = 16'hAAAA; FlagWE = 3'b111; FlagIn = 3'b111;
    SrcReg1 = 4; SrcReg2 = 4;
    settle();
    chk("rst_rd1", SrcData1, 16'h0000);
    chk("rst_rd2", SrcData2, 16'h0000);
    chk("rst_flag", {13'b0, FlagOut}, 16'h0000);
    tick();
    rst = 0; WriteReg = 0; FlagWE = 0; FlagIn = 0;
    for (int i = 0; i < 16; i++) begin
      SrcReg1 = 4'(i); SrcReg2 = 4'(15 - i);
      settle();
      chk($sformatf("reset_r%0d_p1", i), SrcData1, 16'h0000);
      chk($sformatf("reset_r%0d_p2", 15 - i), SrcData2, 16'h0000);
    end
    chk("reset_flags", {13'b0, FlagOut}, 16'h0000);

    // Full-word write R5 = BEEF
    DstReg = 5; WriteReg = 1; WriteMode = 2'b00; DstData = 16'hBEEF; SrcReg1 = 5; SrcReg2 = 5;
    settle();
    chk("r5_full_same", SrcData1, BYP ? 16'hBEEF : 16'h0000);
    tick();
    WriteReg = 0;
    settle();
    chk("r5_full_p1", SrcData1, 16'hBEEF);
    chk("r5_full_p2", SrcData2, 16'hBEEF);

    // Low byte
    WriteReg = 1; WriteMode = 2'b01; DstData = 16'h0012;
    settle();
    chk("r5_low_same", SrcData2, BYP ? 16'hBE12 : 16'hBEEF);
    tick();
    WriteReg = 0;
    settle();
    chk("r5_low", SrcData1, 16'hBE12);

    // High byte
    WriteReg = 1; WriteMode = 2'b10; DstData = 16'h0034;
    settle();
    chk("r5_high_same", SrcData1, BYP ? 16'h3412 : 16'hBE12);
    tick();
    WriteReg = 0;
    settle();
    chk("r5_high", SrcData1, 16'h3412);

    // Reserved mode: no write
    WriteReg = 1; WriteMode = 2'b11; DstData = 16'hFFFF;
    settle();
    chk("r5_rsv_same", SrcData1, 16'h3412);
    tick();
    WriteReg = 0;
    settle();
    chk("r5_rsv", SrcData2, 16'h3412);

    // R0 write discarded, also in the write cycle
    DstReg = 0; WriteReg = 1; WriteMode = 2'b00; DstData = 16'hFFFF; SrcReg1 = 0; SrcReg2 = 0;
    settle();
    chk("r0_same", SrcData1, 16'h0000);
    tick();
    WriteReg = 0;
    settle();
    chk("r0_after", SrcData2, 16'h0000);

    // Flags: per-bit enables
    FlagWE = 3'b101; FlagIn = 3'b111;
    settle();
    chk("flag_a_same", {13'b0, FlagOut}, BYP ? 16'h0005 : 16'h0000);
    tick();
    FlagWE = 3'b010; FlagIn = 3'b000;
    settle();
    chk("flag_b_same", {13'b0, FlagOut}, 16'h0005);
    tick();
    FlagWE = 0;
    settle();
    chk("flag_b", {13'b0, FlagOut}, 16'h0005);

    // Flag and register write in the same cycle
    DstReg = 7; WriteReg = 1; WriteMode = 2'b00; DstData = 16'h00A5; SrcReg1 = 7;
    FlagWE = 3'b100; FlagIn = 3'b000;
    tick();
    WriteReg = 0; FlagWE = 0;
    settle();
    chk("r7_combo", SrcData1, 16'h00A5);
    chk("flag_combo", {13'b0, FlagOut}, 16'h0001);

    // Same-cycle write/read of R3
    DstReg = 3; WriteReg = 1; DstData = 16'h0001; SrcReg1 = 3; SrcReg2 = 5;
    tick();
    DstData = 16'h1234;
    settle();
    chk("r3_same", SrcData1, BYP ? 16'h1234 : 16'h0001);
    chk("r5_other_port", SrcData2, 16'h3412);
    tick();
    WriteReg = 0;
    settle();
    chk("r3_next", SrcData1, 16'h1234);

    // Reset clears everything and forces outputs to 0 while asserted
    rst = 1;
    settle();
    chk("rst2_rd1", SrcData1, 16'h0000);
    chk("rst2_rd2", SrcData2, 16'h0000);
    chk("rst2_flag", {13'b0, FlagOut}, 16'h0000);
    tick();
    rst = 0;
    settle();
    chk("r3_cleared", SrcData1, 16'h0000);
    chk("r5_cleared", SrcData2, 16'h0000);
    SrcReg1 = 7;
    settle();
    chk("r7_cleared", SrcData1, 16'h0000);
    chk("flag_cleared", {13'b0, FlagOut}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
